accum_cpu_param: RTL and testbench

//  Parametrised next-generation accumulator CPU for the io_in/io_out tile.

---
 rtl/accum_cpu_param.sv | 168 ++++++++++++++++
 tb/tb_accum_cpu_param.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_cpu_param.sv
// accum_cpu_param: parametrised single-cycle accumulator CPU.
// Program and data memories are flop arrays loaded through the 2-bit mode port;
// in RUNPROG mode one instruction {opcode[3:0], a[ADDR_W-1:0]} executes per clock.
// Optional feature macro: ACCUM_CPU_MAC_EN builds the opcode-5 multiply-accumulate
// (acc + D*ext_in); without it opcode 5 is a NOP and ext_in is ignored.
module accum_cpu_param #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          mode,
  input  logic [4+ADDR_W-1:0] prog_in,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [DATA_W-1:0]   ext_in,
  input  logic                jump_cond,
  output logic [DATA_W-1:0]   acc,
  output logic [ADDR_W-1:0]   pc,
  output logic                zero,
  output logic                carry,
  output logic                halted
);

  localparam int INSTR_W = 4 + ADDR_W;
  localparam int DEPTH   = 2 ** ADDR_W;

  localparam logic [1:0] MODE_LOADPROG = 2'd0;
  localparam logic [1:0] MODE_LOADDATA = 2'd1;
  localparam logic [1:0] MODE_SETRUNPT = 2'd2;

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_MUL   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_SHL   = 4'h7;
  localparam logic [3:0] OP_SHR   = 4'h8;
  localparam logic [3:0] OP_JMPIF = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hB;

  localparam logic [ADDR_W-1:0] A_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W:0]   SH_LIM = (DATA_W+1)'(DATA_W);

  logic [INSTR_W-1:0] prog [DEPTH];
  logic [DATA_W-1:0]  data [DEPTH];

  logic [INSTR_W-1:0]  instr;
  logic [3:0]          op;
  logic [ADDR_W-1:0]   op_a;
  logic [DATA_W-1:0]   d_rd;
  logic [ADDR_W-1:0]   pc_inc;
  logic [DATA_W:0]     add_sum;
  logic [DATA_W:0]     sub_diff;
  logic [2*DATA_W-1:0] mul_prod;

  logic [DATA_W-1:0]   acc_nx;
  logic [ADDR_W-1:0]   pc_nx;
  logic                carry_nx;
  logic                halt_nx;
  logic                upd_z;
  logic                st_en;

  // Shifts by DATA_W or more clear the word instead of relying on operator semantics.
  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] v,
                                                   input logic [DATA_W-1:0] amt,
                                                   input logic              left);
    if ({1'b0, amt} >= SH_LIM) return '0;
    return left ? (v << amt) : (v >> amt);
  endfunction

  assign instr    = prog[pc];
  assign op       = instr[INSTR_W-1:ADDR_W];
  assign op_a     = instr[ADDR_W-1:0];
  assign d_rd     = data[op_a];
  assign pc_inc   = pc + A_ONE;
  assign add_sum  = {1'b0, acc} + {1'b0, d_rd};
  assign sub_diff = {1'b0, acc} - {1'b0, d_rd};
  assign mul_prod = {{DATA_W{1'b0}}, acc} * {{DATA_W{1'b0}}, d_rd};

`ifdef ACCUM_CPU_MAC_EN
  logic [2*DATA_W-1:0] mac_prod;
  logic [DATA_W:0]     mac_sum;
  assign mac_prod = {{DATA_W{1'b0}}, d_rd} * {{DATA_W{1'b0}}, ext_in};
  assign mac_sum  = {1'b0, acc} + {1'b0, mac_prod[DATA_W-1:0]};
`else
  logic unused_ext;
  assign unused_ext = ^ext_in;
`endif

  // Decode/execute: next architectural state for the instruction at pc.
  always_comb begin
    acc_nx   = acc;
    pc_nx    = pc_inc;
    carry_nx = carry;
    halt_nx  = halted;
    upd_z    = 1'b0;
    st_en    = 1'b0;
    case (op)
      OP_LOAD:  begin acc_nx = d_rd; upd_z = 1'b1; end
      OP_STORE: st_en = 1'b1;
      OP_ADD:   begin acc_nx = add_sum[DATA_W-1:0]; carry_nx = add_sum[DATA_W]; upd_z = 1'b1; end
      OP_MUL:   begin
        acc_nx   = mul_prod[DATA_W-1:0];
        carry_nx = |mul_prod[2*DATA_W-1:DATA_W];
        upd_z    = 1'b1;
      end
`ifdef ACCUM_CPU_MAC_EN
      4'h5:     begin
        acc_nx   = mac_sum[DATA_W-1:0];
        carry_nx = mac_sum[DATA_W] | (|mac_prod[2*DATA_W-1:DATA_W]);
        upd_z    = 1'b1;
      end
`endif
      OP_SUB:   begin acc_nx = sub_diff[DATA_W-1:0]; carry_nx = sub_diff[DATA_W]; upd_z = 1'b1; end
      OP_SHL:   begin acc_nx = shift_word(acc, d_rd, 1'b1); upd_z = 1'b1; end
      OP_SHR:   begin acc_nx = shift_word(acc, d_rd, 1'b0); upd_z = 1'b1; end
      OP_JMPIF: if (jump_cond) pc_nx = op_a;
      OP_JZ:    if (zero) pc_nx = op_a;
      OP_HALT:  begin halt_nx = 1'b1; pc_nx = pc; end
      default:  ;
    endcase
  end

  // Mode-driven state update; reset clears registers and both memories.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc     <= '0;
      acc    <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
      halted <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        prog[i] <= '0;
        data[i] <= '0;
      end
    end else begin
      case (mode)
        MODE_LOADPROG: begin
          prog[pc] <= prog_in;
          pc       <= pc_inc;
        end
        MODE_LOADDATA: begin
          data[pc] <= data_in;
          pc       <= pc_inc;
        end
        MODE_SETRUNPT: begin
          pc     <= prog_in[ADDR_W-1:0];
          acc    <= '0;
          zero   <= 1'b0;
          carry  <= 1'b0;
          halted <= 1'b0;
        end
        default: begin
          if (!halted) begin
            acc    <= acc_nx;
            pc     <= pc_nx;
            carry  <= carry_nx;
            halted <= halt_nx;
            if (upd_z) zero <= (acc_nx == '0);
            if (st_en) data[op_a] <= acc;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_cpu_param.sv
// Directed self-checking bench for accum_cpu_param (DATA_W=4, ADDR_W=4).
module tb_accum_cpu_param;

  logic       clock;
  logic       reset;
  logic [1:0] mode;
  logic [7:0] prog_in;
  logic [3:0] data_in;
  logic [3:0] ext_in;
  logic       jump_cond;
  logic [3:0] acc;
  logic [3:0] pc;
  logic       zero;
  logic       carry;
  logic       halted;

  int checks = 0;
  int errors = 0;

  accum_cpu_param #(.DATA_W(4), .ADDR_W(4)) dut (
    .clock(clock), .reset(reset), .mode(mode), .prog_in(prog_in),
    .data_in(data_in), .ext_in(ext_in), .jump_cond(jump_cond),
    .acc(acc), .pc(pc), .zero(zero), .carry(carry), .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pc(input logic [3:0] a);
    mode = 2'd2; prog_in = {4'h0, a}; tick();
  endtask

  task automatic put_prog(input logic [3:0] a, input logic [7:0] w);
    set_pc(a); mode = 2'd0; prog_in = w; tick();
  endtask

  task automatic put_data(input logic [3:0] a, input logic [3:0] d);
    set_pc(a); mode = 2'd1; data_in = d; tick();
  endtask

  task automatic start(input logic [3:0] a);
    set_pc(a); mode = 2'd3;
  endtask

  task automatic test_reset();
    checks++;
    if ({acc, pc, zero, carry, halted} !== 11'h0) begin
      errors++; $display("FAIL reset_state: got acc=%0d pc=%0d z=%b c=%b h=%b, want all 0", acc, pc, zero, carry, halted);
    end
    put_prog(4'd0, 8'h21);
    put_data(4'd1, 4'd5);
    start(4'd0);
    tick();
    checks++;
    if (acc !== 4'd5 || pc !== 4'd1) begin
      errors++; $display("FAIL pre_reset_run: got acc=%0d pc=%0d, want acc=5 pc=1", acc, pc);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({acc, pc, zero, carry, halted} !== 11'h0) begin
      errors++; $display("FAIL async_reset: got acc=%0d pc=%0d z=%b c=%b h=%b, want all 0", acc, pc, zero, carry, halted);
    end
    #1 reset = 1'b1;
    tick();
    checks++;
    if (acc !== 4'd0 || zero !== 1'b1 || pc !== 4'd1) begin
      errors++; $display("FAIL run_after_reset: got acc=%0d z=%b pc=%0d, want acc=0 z=1 pc=1", acc, zero, pc);
    end
    tick();
    checks++;
    if (acc !== 4'd0 || zero !== 1'b1) begin
      errors++; $display("FAIL data_cleared: got acc=%0d z=%b, want acc=0 z=1", acc, zero);
    end
  endtask

  task automatic test_program();
    put_prog(4'd0, 8'h00);
    put_prog(4'd1, 8'h21);
    put_prog(4'd2, 8'h12);
    put_prog(4'd3, 8'hB0);
    put_data(4'd0, 4'd9);
    put_data(4'd1, 4'd8);
    start(4'd0);
    tick();
    checks++;
    if (acc !== 4'd9 || pc !== 4'd1 || zero !== 1'b0) begin
      errors++; $display("FAIL prog_load: got acc=%0d pc=%0d z=%b, want 9 1 0", acc, pc, zero);
    end
    tick();
    checks++;
    if (acc !== 4'd1 || carry !== 1'b1 || zero !== 1'b0) begin
      errors++; $display("FAIL prog_add: got acc=%0d c=%b z=%b, want 1 1 0", acc, carry, zero);
    end
    tick();
    checks++;
    if (pc !== 4'd3 || acc !== 4'd1) begin
      errors++; $display("FAIL prog_store: got pc=%0d acc=%0d, want 3 1", pc, acc);
    end
    tick();
    checks++;
    if (halted !== 1'b1 || pc !== 4'd3) begin
      errors++; $display("FAIL prog_halt: got h=%b pc=%0d, want 1 3", halted, pc);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (halted !== 1'b1 || pc !== 4'd3 || acc !== 4'd1) begin
        errors++; $display("FAIL halt_hold%0d: got h=%b pc=%0d acc=%0d, want 1 3 1", i, halted, pc, acc);
      end
    end
    put_prog(4'd4, 8'h02);
    start(4'd4);
    tick();
    checks++;
    if (acc !== 4'd1) begin
      errors++; $display("FAIL store_readback: got acc=%0d, want 1", acc);
    end
  endtask

  task automatic test_sub();
    put_prog(4'd0, 8'h00);
    put_prog(4'd1, 8'h61);
    put_prog(4'd2, 8'h01);
    put_prog(4'd3, 8'h61);
    put_data(4'd0, 4'd3);
    put_data(4'd1, 4'd5);
    start(4'd0);
    tick();
    tick();
    checks++;
    if (acc !== 4'd14 || carry !== 1'b1 || zero !== 1'b0) begin
      errors++; $display("FAIL sub_borrow: got acc=%0d c=%b z=%b, want 14 1 0", acc, carry, zero);
    end
    tick();
    tick();
    checks++;
    if (acc !== 4'd0 || carry !== 1'b0 || zero !== 1'b1) begin
      errors++; $display("FAIL sub_zero: got acc=%0d c=%b z=%b, want 0 0 1", acc, carry, zero);
    end
  endtask

  task automatic test_jumps();
    put_prog(4'd2, 8'h97);
    put_prog(4'd7, 8'h0E);
    put_prog(4'd8, 8'hAC);
    jump_cond = 1'b0;
    start(4'd2);
    tick();
    checks++;
    if (pc !== 4'd3) begin
      errors++; $display("FAIL jmpif_not_taken: got pc=%0d, want 3", pc);
    end
    jump_cond = 1'b1;
    start(4'd2);
    tick();
    checks++;
    if (pc !== 4'd7) begin
      errors++; $display("FAIL jmpif_taken: got pc=%0d, want 7", pc);
    end
    jump_cond = 1'b0;
    tick();
    tick();
    checks++;
    if (pc !== 4'd12 || zero !== 1'b1) begin
      errors++; $display("FAIL jz_taken: got pc=%0d z=%b, want 12 1", pc, zero);
    end
  endtask

  task automatic test_wrap_shift();
    logic [7:0] words [16];
    for (int i = 0; i < 16; i++) words[i] = 8'h40;
    words[14] = 8'h03;
    words[0]  = 8'h74;
    words[1]  = 8'h85;
    words[2]  = 8'h71;
    set_pc(4'd0);
    mode = 2'd0;
    for (int i = 0; i < 16; i++) begin
      prog_in = words[i];
      tick();
    end
    checks++;
    if (pc !== 4'd0) begin
      errors++; $display("FAIL loadprog_wrap: got pc=%0d, want 0", pc);
    end
    put_data(4'd1, 4'd4);
    put_data(4'd3, 4'd6);
    put_data(4'd4, 4'd1);
    put_data(4'd5, 4'd2);
    start(4'd14);
    tick();
    tick();
    checks++;
    if (pc !== 4'd0 || acc !== 4'd6) begin
      errors++; $display("FAIL run_wrap: got pc=%0d acc=%0d, want 0 6", pc, acc);
    end
    tick();
    checks++;
    if (acc !== 4'd12 || zero !== 1'b0) begin
      errors++; $display("FAIL shl_1: got acc=%0d z=%b, want 12 0", acc, zero);
    end
    tick();
    checks++;
    if (acc !== 4'd3) begin
      errors++; $display("FAIL shr_2: got acc=%0d, want 3", acc);
    end
    tick();
    checks++;
    if (acc !== 4'd0 || zero !== 1'b1) begin
      errors++; $display("FAIL shl_full: got acc=%0d z=%b, want 0 1", acc, zero);
    end
  endtask

  task automatic test_mul_mac();
    logic [3:0] exp_acc;
    logic       exp_c;
    put_prog(4'd0, 8'h06);
    put_prog(4'd1, 8'h57);
    put_prog(4'd2, 8'h06);
    put_prog(4'd3, 8'h57);
    put_prog(4'd4, 8'h08);
    put_prog(4'd5, 8'h37);
    put_data(4'd6, 4'd2);
    put_data(4'd7, 4'd3);
    put_data(4'd8, 4'd6);
    ext_in = 4'd4;
    start(4'd0);
    tick();
    tick();
`ifdef ACCUM_CPU_MAC_EN
    exp_acc = 4'd14; exp_c = 1'b0;
`else
    exp_acc = 4'd2;  exp_c = 1'b0;
`endif
    checks++;
    if (acc !== exp_acc || carry !== exp_c || pc !== 4'd2) begin
      errors++; $display("FAIL mac_ext4: got acc=%0d c=%b pc=%0d, want %0d %b 2", acc, carry, pc, exp_acc, exp_c);
    end
    ext_in = 4'd5;
    tick();
    tick();
`ifdef ACCUM_CPU_MAC_EN
    exp_acc = 4'd1; exp_c = 1'b1;
`else
    exp_acc = 4'd2; exp_c = 1'b0;
`endif
    checks++;
    if (acc !== exp_acc || carry !== exp_c || pc !== 4'd4) begin
      errors++; $display("FAIL mac_ext5: got acc=%0d c=%b pc=%0d, want %0d %b 4", acc, carry, pc, exp_acc, exp_c);
    end
    tick();
    tick();
    checks++;
    if (acc !== 4'd2 || carry !== 1'b1 || zero !== 1'b0) begin
      errors++; $display("FAIL mul_ovf: got acc=%0d c=%b z=%b, want 2 1 0", acc, carry, zero);
    end
  endtask

  initial begin
    reset = 1'b0;
    mode = 2'd2;
    prog_in = 8'h00;
    data_in = 4'h0;
    ext_in = 4'h0;
    jump_cond = 1'b0;
    #2;
    test_reset_state_hold: begin end
    #10 reset = 1'b1;
    test_reset();
    test_program();
    test_sub();
    test_jumps();
    test_wrap_shift();
    test_mul_mac();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
